// File: rtl/batch_sequencer_if.sv
// ---------------------------------------------------------------------------
// batch_sequencer_if
//   Bus between the batch sequencer and the control-bounded filter datapath.
//   Carries the downsampled sample strobe toward the sequencer and all
//   memory addresses / recursion strobes back toward the datapath.
//
//   Parameters : DEPTH (batch length in input samples), OSR (oversampling).
//   Signals    : en              - downsampled sample strobe
//                sample_addr_*   - sample-memory addresses (in, lh, fr, br)
//                res_addr_*      - partial-result memory addresses
//                reg_prop_n      - recursion-register propagation strobe
//                out_valid       - datapath output meaningful (sticky)
//   Modports   : master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface batch_sequencer_if #(
  parameter int DEPTH = 220,
  parameter int OSR   = 1
);
  localparam int DS_DEPTH = (DEPTH + OSR - 1) / OSR;
  localparam int CW       = (DS_DEPTH > 1) ? $clog2(DS_DEPTH) : 1;
  localparam int SAW      = CW + 2;
  localparam int RAW      = CW + 1;

  logic           en;
  logic [SAW-1:0] sample_addr_in;
  logic [SAW-1:0] sample_addr_lh;
  logic [SAW-1:0] sample_addr_fr;
  logic [SAW-1:0] sample_addr_br;
  logic [RAW-1:0] res_addr_in;
  logic [RAW-1:0] res_addr_out_f;
  logic [RAW-1:0] res_addr_out_b;
  logic           reg_prop_n;
  logic           out_valid;

  modport master (
    input  en,
    output sample_addr_in, sample_addr_lh, sample_addr_fr, sample_addr_br,
    output res_addr_in, res_addr_out_f, res_addr_out_b,
    output reg_prop_n, out_valid
  );

  modport slave (
    output en,
    input  sample_addr_in, sample_addr_lh, sample_addr_fr, sample_addr_br,
    input  res_addr_in, res_addr_out_f, res_addr_out_b,
    input  reg_prop_n, out_valid
  );
endinterface

// File: rtl/batch_sequencer.sv
// ---------------------------------------------------------------------------
// batch_sequencer
//   Address and timing controller for the batch-mode control-bounded filter
//   datapath. Runs on the system clock, advancing only on the downsampled
//   sample strobe (bus.en). Produces the sample-memory write / lookahead /
//   forward / backward read addresses, the partial-result memory addresses,
//   the recursion-register propagation strobe and a warm-up valid flag.
//
//   Ports:
//     clk         system clock
//     rst         asynchronous active-low reset
//     bus         batch_sequencer_if.master (en in, addresses/strobes out)
//   Optional (macro BATCH_SEQ_STATUS_EN defined):
//     batch_done  one-clock pulse on the batch wrap strobe
//     batch_num   16-bit count of completed batches, wraps at 2^16
//
//   Parameters DEPTH/OSR must match those of the connected interface.
// ---------------------------------------------------------------------------
module batch_sequencer #(
  parameter int DEPTH = 220,
  parameter int OSR   = 1
) (
  input  logic                clk,
  input  logic                rst,
  batch_sequencer_if.master   bus
`ifdef BATCH_SEQ_STATUS_EN
  ,
  output logic                batch_done,
  output logic [15:0]         batch_num
`endif
);

  localparam int DS_DEPTH = (DEPTH + OSR - 1) / OSR;
  localparam int CW       = (DS_DEPTH > 1) ? $clog2(DS_DEPTH) : 1;
  localparam int SAW      = CW + 2;
  localparam int RAW      = CW + 1;
  localparam logic [CW-1:0] LAST = CW'(DS_DEPTH - 1);

  logic [CW-1:0]  count, rev;
  logic [1:0]     cycle, cycle_lh, cycle_idle, cycle_calc;
  logic [CW-1:0]  count_d1, count_d2, count_d3;
  logic [CW-1:0]  rev_d1, rev_d2;
  // Only the bank parity reaches the result addresses, so only bit 0 of
  // the write bank is carried down the delay line.
  logic           par_d1, par_d2, par_d3;

  logic [SAW-1:0] addr_in_q, addr_lh_q, addr_fr_q, addr_br_q;
  logic [RAW-1:0] res_in_q, res_f_q, res_b_q;
  logic           reg_prop_n_q, out_valid_q;
  logic           wrap;

  assign wrap = (count == LAST);

  // Main sequencer state. Every output register samples the state as it was
  // before this strobe's update, so outputs lag the strobe edge by 1 clock.
  // At batch end the four banks rotate: the bank just written becomes the
  // lookahead bank, lookahead becomes idle, idle becomes the compute bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      rev          <= LAST;
      cycle        <= 2'd0;
      cycle_lh     <= 2'd3;
      cycle_idle   <= 2'd2;
      cycle_calc   <= 2'd1;
      count_d1     <= '0;
      count_d2     <= '0;
      count_d3     <= '0;
      rev_d1       <= '0;
      rev_d2       <= '0;
      par_d1       <= 1'b0;
      par_d2       <= 1'b0;
      par_d3       <= 1'b0;
      addr_in_q    <= '0;
      addr_lh_q    <= '0;
      addr_fr_q    <= '0;
      addr_br_q    <= '0;
      res_in_q     <= '0;
      res_f_q      <= '0;
      res_b_q      <= '0;
      reg_prop_n_q <= 1'b1;
      out_valid_q  <= 1'b0;
    end else if (bus.en) begin
      addr_in_q    <= {count, cycle};
      addr_lh_q    <= {rev, cycle_lh};
      addr_fr_q    <= {count, cycle_calc};
      addr_br_q    <= {rev, cycle_calc};
      res_in_q     <= {count_d3, par_d3};
      res_f_q      <= {count_d2, ~par_d2};
      res_b_q      <= {rev_d2, ~par_d2};
      reg_prop_n_q <= !wrap;
      // Bank index 3 first appears on the write bank at the start of the
      // fourth batch, by which point the pipeline holds real data.
      out_valid_q  <= out_valid_q | (cycle == 2'd3);

      count_d1     <= count;
      count_d2     <= count_d1;
      count_d3     <= count_d2;
      rev_d1       <= rev;
      rev_d2       <= rev_d1;
      par_d1       <= cycle[0];
      par_d2       <= par_d1;
      par_d3       <= par_d2;

      if (wrap) begin
        count      <= '0;
        rev        <= LAST;
        cycle      <= cycle + 2'd1;
        cycle_lh   <= cycle;
        cycle_idle <= cycle_lh;
        cycle_calc <= cycle_idle;
      end else begin
        count      <= count + CW'(1);
        rev        <= rev - CW'(1);
      end
    end
  end

  assign bus.sample_addr_in = addr_in_q;
  assign bus.sample_addr_lh = addr_lh_q;
  assign bus.sample_addr_fr = addr_fr_q;
  assign bus.sample_addr_br = addr_br_q;
  assign bus.res_addr_in    = res_in_q;
  assign bus.res_addr_out_f = res_f_q;
  assign bus.res_addr_out_b = res_b_q;
  assign bus.reg_prop_n     = reg_prop_n_q;
  assign bus.out_valid      = out_valid_q;

`ifdef BATCH_SEQ_STATUS_EN
  // batch_done is re-evaluated every clock (not only on strobes) so that it
  // stays exactly one clock wide even when en drops right after the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      batch_done <= 1'b0;
      batch_num  <= 16'd0;
    end else begin
      batch_done <= bus.en && wrap;
      if (bus.en && wrap) begin
        batch_num <= batch_num + 16'd1;
      end
    end
  end
`endif

endmodule
